// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks: the four-state
// control encoding used by the multiplier and divider, and a width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'h0,
    ST_LATCH = 2'h1,
    ST_CALC  = 2'h2,
    ST_DONE  = 2'h3
  } state_t;

  // Bits needed to count 0..n-1; never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring-divider datapath: operand/partial registers, the compare-subtract
// step and the result registers that are published only on the last step.
module div_datapath
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             last,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] r_step;
  logic             ge;

  // r[WIDTH] is always zero here, so widening t by it leaves the step unchanged.
  always_comb begin
    t      = {r, q[WIDTH-1]};
    ge     = (t >= {2'b00, d});
    r_step = ge ? (t - {2'b00, d}) : t;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (load) begin
        d <= divisor;
        q <= dividend;
        r <= '0;
      end else if (step) begin
        r <= (WIDTH+1)'(r_step);
        q <= {q[WIDTH-2:0], ge};
      end
      if (last) begin
        quotient    <= {q[WIDTH-2:0], ge};
        remainder   <= WIDTH'(r_step);
        div_by_zero <= (d == '0);
      end
    end
  end

endmodule

// File: rtl/div4_seq.sv
// Sequential unsigned divider, one quotient bit per clock, driven by the same
// INIT/LATCH/CALC/DONE control protocol as the shift-add multiplier.
module div4_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             done,
  output logic [1:0]       state_out
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_INIT;
      count <= '0;
    end else begin
      state <= state_next;
      if (state == ST_LATCH)
        count <= CNT_LAST;
      else if (state == ST_CALC)
        count <= count - CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (trig) state_next = ST_LATCH;
      ST_LATCH: state_next = ST_CALC;
      ST_CALC:  if (count == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_INIT;
      default:  state_next = ST_INIT;
    endcase
  end

  assign last      = (state == ST_CALC) && (count == '0);
  assign done      = (state == ST_DONE);
  assign state_out = state;

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (state == ST_LATCH),
    .step       (state == ST_CALC),
    .last       (last),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

endmodule

// File: tb/tb_div4_seq.sv
// Self-checking bench for div4_seq: expected results are queued when an
// operation is started and compared when done is seen.
module tb_div4_seq;

  logic       clk;
  logic       rst;
  logic       trig;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       done;
  logic [1:0] state_out;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  div4_seq #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .done       (done),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 4'hF; e.r = 4'(a); e.dz = 1'b1;
    end else begin
      e.q = 4'(a / b); e.r = 4'(a % b); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge while in INIT; returns at the negedge in LATCH.
  task automatic start_op(input int a, input int b);
    dividend = 4'(a);
    divisor  = 4'(b);
    trig     = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; trig = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (state_out !== 2'd0 || quotient !== 4'd0 || remainder !== 4'd0 ||
          done !== 1'b0 || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d: got st=%0d q=%0d r=%0d done=%b dz=%b, want all 0",
                 i, state_out, quotient, remainder, done, div_by_zero);
      end
    end
  endtask

  task automatic test_basic;
    int   seq[7] = '{1, 2, 2, 2, 2, 3, 0};
    exp_t e;
    dividend = 4'd13; divisor = 4'd4; trig = 1'b1;
    sb.push_back(model(13, 4));
    e = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      trig = 1'b0;
      n_checks++;
      if (state_out !== 2'(seq[i]) || done !== (seq[i] == 3)) begin
        n_fail++;
        $display("FAIL basic_seq step%0d: got st=%0d done=%b, want st=%0d done=%b",
                 i, state_out, done, seq[i], (seq[i] == 3));
      end
      if (i < 5) begin
        n_checks++;
        if (quotient !== 4'd0 || remainder !== 4'd0) begin
          n_fail++;
          $display("FAIL basic_hold_prev step%0d: got q=%0d r=%0d, want 0/0", i, quotient, remainder);
        end
      end
      if (seq[i] == 3) begin
        e = sb.pop_front();
        n_checks++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
          n_fail++;
          $display("FAIL basic_13_4: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                   quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
      end
    end
    n_checks++;
    if (quotient !== 4'd3 || remainder !== 4'd1) begin
      n_fail++;
      $display("FAIL basic_hold_after: got q=%0d r=%0d, want q=3 r=1", quotient, remainder);
    end
  endtask

  task automatic test_corners;
    int a_tab[4] = '{15, 3, 15, 0};
    int b_tab[4] = '{1, 9, 15, 7};
    bit ok; int n; exp_t e;
    for (int i = 0; i < 4; i++) begin
      start_op(a_tab[i], b_tab[i]);
      wait_done(ok, n);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL corner_timeout %0d/%0d: no done, want done after 5 cycles", a_tab[i], b_tab[i]);
        sb.delete();
      end else begin
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
          n_fail++;
          $display("FAIL corner %0d/%0d: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                   a_tab[i], b_tab[i], quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    int a_tab[2] = '{7, 8};
    int b_tab[2] = '{0, 2};
    bit ok; int n; exp_t e;
    for (int i = 0; i < 2; i++) begin
      start_op(a_tab[i], b_tab[i]);
      wait_done(ok, n);
      n_checks++;
      if (!ok || n != 5) begin
        n_fail++;
        $display("FAIL dz_latency %0d/%0d: got done=%b after %0d cycles, want done after 5",
                 a_tab[i], b_tab[i], ok, n);
      end
      if (ok) begin
        e = sb.pop_front();
        n_checks++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
          n_fail++;
          $display("FAIL dz_result %0d/%0d: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                   a_tab[i], b_tab[i], quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
      end else sb.delete();
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int   got = 0;
    int   last_t = -1;
    exp_t e;
    dividend = 4'd9; divisor = 4'd2; trig = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(model(9, 2));
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      @(negedge clk);
      if (done) begin
        e = sb.pop_front();
        n_checks++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
          n_fail++;
          $display("FAIL b2b_result #%0d: got q=%0d r=%0d, want q=%0d r=%0d",
                   got, quotient, remainder, e.q, e.r);
        end
        if (last_t >= 0) begin
          n_checks++;
          if (cyc - last_t != 7) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d cycles between done, want 7", cyc - last_t);
          end
        end
        last_t = cyc;
        got++;
        if (got == 3) trig = 1'b0;
      end
    end
    trig = 1'b0;
    n_checks++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", got);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_noise;
    bit   seen = 1'b0;
    exp_t e;
    start_op(13, 4);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        trig = 1'b0;
      end else begin
        trig     = 1'($urandom_range(0, 1));
        dividend = 4'($urandom_range(0, 15));
        divisor  = 4'($urandom_range(0, 15));
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL noise_timeout: no done, want done");
      sb.delete();
    end else begin
      e = sb.pop_front();
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        n_fail++;
        $display("FAIL noise_13_4: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                 quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok; int n; exp_t e;
    int spurious = 0;
    start_op(12, 5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_out !== 2'd0 || quotient !== 4'd0 || remainder !== 4'd0 ||
        done !== 1'b0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear: got st=%0d q=%0d r=%0d done=%b dz=%b, want all 0",
               state_out, quotient, remainder, done, div_by_zero);
    end
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || state_out !== 2'd0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL midreset_idle: got %0d cycles with done/non-INIT, want 0", spurious);
    end
    start_op(12, 5);
    wait_done(ok, n);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL restart_timeout: no done, want done");
      sb.delete();
    end else begin
      e = sb.pop_front();
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        n_fail++;
        $display("FAIL restart_12_5: got q=%0d r=%0d, want q=%0d r=%0d",
                 quotient, remainder, e.q, e.r);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sweep;
    bit ok; int n; exp_t e;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        start_op(a, b);
        wait_done(ok, n);
        n_checks++;
        if (!ok) begin
          n_fail++;
          $display("FAIL sweep_timeout %0d/%0d: no done, want done", a, b);
          sb.delete();
        end else begin
          e = sb.pop_front();
          if (quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0 ||
              (int'(quotient) * b + int'(remainder)) != a || int'(remainder) >= b) begin
            n_fail++;
            $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=0",
                     a, b, quotient, remainder, div_by_zero, e.q, e.r);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_back_to_back();
    test_noise();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div4_seq.md
Name: div4_seq

Overview:
Sequential restoring divider that is the inverse companion of the shift-add multiplier.
- Computes quotient and remainder of two unsigned WIDTH-bit operands, one bit per clock.
- Uses the same four-state control protocol as the multiplier: INIT, LATCH, CALC, DONE.
- Sits beside the multiplier in the arithmetic unit. Shares its trigger/state interface so the same top-level sequencer can drive either block.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
trig  input  1  start request, sampled only in INIT
dividend  input  WIDTH  unsigned dividend, captured in LATCH
divisor  input  WIDTH  unsigned divisor, captured in LATCH
quotient  output  WIDTH  registered quotient, held until next completion
remainder  output  WIDTH  registered remainder, held until next completion
div_by_zero  output  1  registered; set when the completed operation had divisor==0
done  output  1  high for exactly the one cycle the FSM is in DONE
state_out  output  2  current state (INIT=0, LATCH=1, CALC=2, DONE=3)

Behaviour:
- Reset (rst==0 at posedge clk):
  - State goes to INIT.
  - quotient, remainder, div_by_zero, done are 0.
  - Working regs and count are 0.
  - Reset takes priority in every state, including mid-CALC. A partial result is never published.
- INIT:
  - trig==1 -> LATCH. Otherwise stay.
  - trig is ignored in every other state.
- LATCH (1 cycle), at the edge leaving it:
  - D <= divisor; Q <= dividend; R <= 0 (WIDTH+1 bits).
  - count <= WIDTH-1 (count width = clog2(WIDTH)).
  - State -> CALC.
- CALC (exactly WIDTH cycles), one restoring step per edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - If T >= {1'b0,D}: R <= T - D, Q <= {Q[WIDTH-2:0],1}.
  - Else: R <= T, Q <= {Q[WIDTH-2:0],0}.
  - count <= count-1 (wraps, don't care after the last step).
  - When count==0 during a CALC cycle, that step is the last. At the same edge:
    - state -> DONE;
    - quotient <= final Q;
    - remainder <= final R[WIDTH-1:0];
    - div_by_zero <= (D==0).
- DONE (1 cycle): done=1, then -> INIT.
- Latency: trig sampled at edge k -> done high in the cycle after edge k+WIDTH+1 (k+5 for WIDTH=4). Results are valid from that cycle on.
- Throughput: one result per WIDTH+3 cycles with trig held high. The block spends one cycle in INIT between operations.
- Divide by zero:
  - No special path. The algorithm naturally yields quotient = all ones and remainder = dividend.
  - div_by_zero=1 flags it. Latency is unchanged.
- Outputs hold the previous result through INIT, LATCH and CALC of the next operation. They change only at the edge entering DONE.
- Operand inputs may change freely outside the LATCH cycle.
- Invariant (divisor!=0): dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared package arith_pkg holds:
  - state constants ST_INIT=2'h0, ST_LATCH=2'h1, ST_CALC=2'h2, ST_DONE=2'h3 (same encoding as the multiplier FSM);
  - the state type;
  - a clog2 helper for the count width.
- Natural sub-module: div_datapath. It holds the R/Q/D registers, the compare-subtract step and the result registers.
- The top keeps the FSM and the counter. The FSM part is structurally identical to the multiplier controller and may be shared.

Test Plan:
- rst low 2 cycles, then high, trig=0 -> state_out=0, quotient=0, remainder=0, done=0, div_by_zero=0 held.
- dividend=13, divisor=4, trig pulse -> state sequence 1,2,2,2,2,3,0; done one cycle at k+5; quotient=3, remainder=1, div_by_zero=0.
- 15/1 -> q=15 r=0; 3/9 -> q=0 r=3; 15/15 -> q=1 r=0; exhaustive 16x15 nonzero-divisor sweep checks the invariant.
- dividend=7, divisor=0 -> quotient=15, remainder=7, div_by_zero=1, same latency; next op 8/2 -> q=4 r=0, div_by_zero=0.
- trig held high continuously with operands 9/2 -> done every 7 cycles, q=4 r=1. trig pulses and operand changes during CALC do not alter the result.
- Start 12/5, assert rst in 2nd CALC cycle -> next cycle state_out=0, outputs 0, no done. Restart 12/5 -> q=2 r=2.
